// File: rtl/dcp_dump_if.sv
// Command, SCAN, PRINT and memory signals of the memory dump block in one bundle.
// The slave modport is the dump block; master is whoever drives commands and serves it.
interface dcp_dump_if #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int NCH = 2
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic               start;
    logic [CHW-1:0]     ch;
    logic               finish;
    logic               req_rx;
    logic               type_rx;
    logic               ack_rx;
    logic               flag_rx;
    logic [31:0]        din_rx;
    logic               req_tx;
    logic               type_tx;
    logic               ack_tx;
    logic [31:0]        dout_tx;
    logic [AW-1:0]      addr;
    logic [NCH*DW-1:0]  rd_data;
    logic [3:0]         state_dbg;

    // Handshakes: req_rx/req_tx are held high until the partner returns a one-cycle
    // ack; an ack seen while the matching req is low has no effect, and each req
    // drops the cycle after its ack.
    modport master (
        output start, ch, ack_rx, flag_rx, din_rx, ack_tx, rd_data,
        input  finish, req_rx, type_rx, req_tx, type_tx, dout_tx, addr, state_dbg
    );

    modport slave (
        input  start, ch, ack_rx, flag_rx, din_rx, ack_tx, rd_data,
        output finish, req_rx, type_rx, req_tx, type_tx, dout_tx, addr, state_dbg
    );
endinterface

// File: rtl/dcp_dump.sv
// Memory dump command: fetch a start address from SCAN, then print NWORDS lines
// "addr:data\n" through PRINT, reading one word per line from the selected channel.
module dcp_dump #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int NCH    = 2,
    parameter int NWORDS = 8,
    parameter int STEP   = 4
) (
    input  logic      clk,
    input  logic      rstn,
    dcp_dump_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ARG     = 4'd1,
        RD      = 4'd2,
        P_ADDR  = 4'd3,
        P_COLON = 4'd4,
        P_DATA  = 4'd5,
        P_NL    = 4'd6,
        NEXT    = 4'd7,
        DONE    = 4'd8
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [CHW-1:0] ch_r;
    logic [AW-1:0]  cur_addr;
    logic [AW-1:0]  last_addr;
    logic [31:0]    data_r;
    logic [CW-1:0]  cnt;
    logic           tx_done;
    logic [31:0]    rd_sel;
    logic [31:0]    addr_ext;
    logic           is_print;
    logic           req_tx_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_n;
    end

    // tx_done marks the gap cycle after an ack, so req_tx always drops between prints.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start)  state_n = ARG;
            ARG:     if (bus.ack_rx) state_n = RD;
            RD:      state_n = P_ADDR;
            P_ADDR:  if (tx_done)    state_n = P_COLON;
            P_COLON: if (tx_done)    state_n = P_DATA;
            P_DATA:  if (tx_done)    state_n = P_NL;
            P_NL:    if (tx_done)    state_n = NEXT;
            NEXT:    state_n = (cnt == CW'(NWORDS - 1)) ? DONE : RD;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Channels at or beyond NCH leave rd_sel at zero.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_r == CHW'(k)) rd_sel[DW-1:0] = bus.rd_data[k*DW +: DW];
        end
    end

    always_comb begin
        addr_ext = '0;
        addr_ext[AW-1:0] = cur_addr;
    end

    always_comb begin
        is_print = (state == P_ADDR) || (state == P_COLON) ||
                   (state == P_DATA) || (state == P_NL);
        req_tx_i = is_print && !tx_done;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch_r      <= '0;
            cur_addr  <= '0;
            last_addr <= '0;
            data_r    <= '0;
            cnt       <= '0;
            tx_done   <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) ch_r <= bus.ch;
            if (state == ARG && bus.ack_rx) begin
                cur_addr <= bus.flag_rx ? last_addr
                                        : (bus.din_rx[AW-1:0] & ~AW'(STEP - 1));
                cnt      <= '0;
            end
            if (state == RD) data_r <= rd_sel;
            if (req_tx_i && bus.ack_tx) tx_done <= 1'b1;
            else if (tx_done)           tx_done <= 1'b0;
            if (state == NEXT) begin
                cur_addr <= cur_addr + AW'(STEP);
                cnt      <= cnt + 1'b1;
            end
            if (state == DONE) last_addr <= cur_addr;
        end
    end

    always_comb begin
        bus.req_rx    = (state == ARG);
        bus.type_rx   = (state == ARG);
        bus.req_tx    = req_tx_i;
        bus.type_tx   = (state == P_ADDR) || (state == P_DATA);
        bus.finish    = (state == DONE);
        bus.state_dbg = state;
        bus.addr      = '0;
        bus.dout_tx   = '0;
        if (is_print || state == RD || state == NEXT) bus.addr = cur_addr;
        case (state)
            P_ADDR:  bus.dout_tx = addr_ext;
            P_COLON: bus.dout_tx = 32'h0000_003A;
            P_DATA:  bus.dout_tx = data_r;
            P_NL:    bus.dout_tx = 32'h0000_000A;
            default: bus.dout_tx = '0;
        endcase
    end
endmodule

// File: tb/tb_dcp_dump.sv
// Directed bench for dcp_dump: command driver, PRINT responder, memory model,
// per-scenario tasks with inline checks and a one-line report.
module tb_dcp_dump;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int NCH    = 3;
    localparam int NWORDS = 8;
    localparam int STEP   = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    dcp_dump_if #(.AW(AW), .DW(DW), .NCH(NCH)) bus ();

    dcp_dump #(.AW(AW), .DW(DW), .NCH(NCH), .NWORDS(NWORDS), .STEP(STEP)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests   = 0;
    int n_fail    = 0;
    int ack_dly_max = 0;
    bit spurious_en = 1'b0;
    int stab_err  = 0;
    int order_err = 0;
    int fin_cnt   = 0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    // ch0 = addr ^ A5A50000, ch1 = ~addr, ch2 = addr + 22220000
    assign bus.rd_data = {bus.addr + 32'h2222_0000, ~bus.addr, bus.addr ^ 32'hA5A5_0000};

    function automatic logic [31:0] mem_word(input logic [1:0] c, input logic [31:0] a);
        case (c)
            2'd0:    return a ^ 32'hA5A5_0000;
            2'd1:    return ~a;
            2'd2:    return a + 32'h2222_0000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic build_exp(input logic [1:0] c, input logic [31:0] base);
        logic [31:0] a;
        exp_q.delete();
        for (int w = 0; w < NWORDS; w++) begin
            a = base + 32'(w * STEP);
            exp_q.push_back({1'b1, a});
            exp_q.push_back({1'b0, 32'h3A});
            exp_q.push_back({1'b1, mem_word(c, a)});
            exp_q.push_back({1'b0, 32'h0A});
        end
    endtask

    function automatic int seq_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    initial begin : print_responder
        logic [32:0] held;
        int d;
        bus.ack_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && bus.req_tx === 1'b1) begin
                held = {bus.type_tx, bus.dout_tx};
                got_q.push_back(held);
                d = $urandom_range(0, ack_dly_max);
                for (int i = 0; i < d && rstn; i++) begin
                    @(negedge clk);
                    if (rstn && (bus.req_tx !== 1'b1 || {bus.type_tx, bus.dout_tx} !== held))
                        stab_err++;
                end
                bus.ack_tx = 1'b1;
                @(negedge clk);
                bus.ack_tx = 1'b0;
            end else if (rstn && spurious_en && $urandom_range(0, 2) == 0) begin
                bus.ack_tx = 1'b1;
                @(negedge clk);
                bus.ack_tx = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (bus.req_rx && bus.req_tx) order_err++;
            if (bus.finish && (bus.req_rx || bus.req_tx)) order_err++;
            if (bus.finish) fin_cnt++;
        end
    end

    task automatic issue_cmd(input logic [1:0] c, input logic [31:0] din, input logic flag);
        int n;
        got_q.delete();
        @(negedge clk);
        bus.start = 1'b1;
        bus.ch    = c;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.req_rx !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        n_tests++;
        if (bus.req_rx !== 1'b1 || bus.type_rx !== 1'b1) begin
            n_fail++;
            $display("FAIL arg_req: req_rx=%b type_rx=%b, required 1/1", bus.req_rx, bus.type_rx);
        end
        bus.din_rx  = din;
        bus.flag_rx = flag;
        bus.ack_rx  = 1'b1;
        @(negedge clk);
        bus.ack_rx  = 1'b0;
        bus.flag_rx = 1'b0;
        bus.din_rx  = 32'h0;
    endtask

    task automatic run_cmd(input logic [1:0] c, input logic [31:0] din, input logic flag,
                           output int lat);
        int n;
        issue_cmd(c, din, flag);
        n = 0;
        while (bus.finish !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        lat = n;
        n_tests++;
        if (bus.finish !== 1'b1) begin
            n_fail++;
            $display("FAIL finish_timeout: finish=%b after %0d cycles, required 1", bus.finish, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.req_rx, bus.type_rx, bus.req_tx, bus.type_tx, bus.finish} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {bus.req_rx, bus.type_rx, bus.req_tx, bus.type_tx, bus.finish});
        end
        n_tests++;
        if (bus.addr !== '0 || bus.dout_tx !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h dout_tx=%h, required 0/0", bus.addr, bus.dout_tx);
        end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if (bus.state_dbg !== 4'd0 || bus.req_rx !== 1'b0 || bus.addr !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: state=%0d req_rx=%b addr=%h, required 0/0/0",
                     bus.state_dbg, bus.req_rx, bus.addr);
        end
    endtask

    task automatic test_basic();
        int lat, f0, d;
        f0 = fin_cnt;
        run_cmd(2'd0, 32'h0000_1003, 1'b0, lat);
        n_tests++;
        if (got_q.size() !== 32) begin
            n_fail++;
            $display("FAIL basic_count: got %0d prints, required 32", got_q.size());
        end
        n_tests++;
        if (got_q[0] !== {1'b1, 32'h0000_1000} || got_q[1] !== {1'b0, 32'h3A}) begin
            n_fail++;
            $display("FAIL basic_first: got %h %h, required 100001000 00000003a", got_q[0], got_q[1]);
        end
        n_tests++;
        if (got_q[2] !== {1'b1, 32'hA5A5_1000} || got_q[3] !== {1'b0, 32'h0A}) begin
            n_fail++;
            $display("FAIL basic_data: got %h %h, required 1a5a51000 00000000a", got_q[2], got_q[3]);
        end
        n_tests++;
        if (got_q[28] !== {1'b1, 32'h0000_101C}) begin
            n_fail++;
            $display("FAIL basic_last_addr: got %h, required 10000101c", got_q[28]);
        end
        build_exp(2'd0, 32'h0000_1000);
        d = seq_diff();
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL basic_seq: first diff at %0d, got size %0d, required size %0d",
                     d, got_q.size(), exp_q.size());
        end
        n_tests++;
        if (lat !== 80) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, required 80", lat);
        end
        n_tests++;
        if (fin_cnt - f0 !== 1) begin
            n_fail++;
            $display("FAIL basic_finish_pulses: got %0d, required 1", fin_cnt - f0);
        end
    endtask

    task automatic test_continue();
        int lat, d;
        run_cmd(2'd0, 32'hDEAD_BEEF, 1'b1, lat);
        build_exp(2'd0, 32'h0000_1020);
        d = seq_diff();
        n_tests++;
        if (d != -1 || got_q[0] !== {1'b1, 32'h0000_1020}) begin
            n_fail++;
            $display("FAIL continue_1020: diff at %0d, first print %h, required 100001020", d, got_q[0]);
        end
        run_cmd(2'd0, 32'h0000_0000, 1'b1, lat);
        n_tests++;
        if (got_q[0] !== {1'b1, 32'h0000_1040}) begin
            n_fail++;
            $display("FAIL continue_1040: first print %h, required 100001040", got_q[0]);
        end
    endtask

    task automatic test_channels();
        int lat, d;
        run_cmd(2'd1, 32'h0000_0000, 1'b0, lat);
        build_exp(2'd1, 32'h0);
        d = seq_diff();
        n_tests++;
        if (d != -1 || got_q[2] !== {1'b1, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL ch1_data: diff at %0d, word0 %h, required 1ffffffff", d, got_q[2]);
        end
        run_cmd(2'd2, 32'h0000_0040, 1'b0, lat);
        build_exp(2'd2, 32'h40);
        d = seq_diff();
        n_tests++;
        if (d != -1 || got_q[2] !== {1'b1, 32'h2222_0040}) begin
            n_fail++;
            $display("FAIL ch2_data: diff at %0d, word0 %h, required 122220040", d, got_q[2]);
        end
        run_cmd(2'd3, 32'h0000_0080, 1'b0, lat);
        build_exp(2'd3, 32'h80);
        d = seq_diff();
        n_tests++;
        if (d != -1 || got_q[2] !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL ch_oob_zero: diff at %0d, word0 %h, required 100000000", d, got_q[2]);
        end
    endtask

    task automatic test_wrap();
        int lat, d;
        run_cmd(2'd0, 32'hFFFF_FFF0, 1'b0, lat);
        build_exp(2'd0, 32'hFFFF_FFF0);
        d = seq_diff();
        n_tests++;
        if (d != -1 || got_q[12] !== {1'b1, 32'hFFFF_FFFC} || got_q[16] !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_seq: diff at %0d, word3 %h word4 %h, required 1fffffffc 100000000",
                     d, got_q[12], got_q[16]);
        end
        run_cmd(2'd1, 32'h0, 1'b1, lat);
        n_tests++;
        if (got_q[0] !== {1'b1, 32'h0000_0010}) begin
            n_fail++;
            $display("FAIL wrap_last_addr: first print %h, required 100000010", got_q[0]);
        end
    endtask

    task automatic test_delays();
        int lat, d;
        ack_dly_max = 5;
        spurious_en = 1'b1;
        stab_err    = 0;
        run_cmd(2'd0, 32'h0000_0207, 1'b0, lat);
        ack_dly_max = 0;
        spurious_en = 1'b0;
        build_exp(2'd0, 32'h0000_0204);
        d = seq_diff();
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL delay_seq: first diff at %0d, got size %0d, required size %0d",
                     d, got_q.size(), exp_q.size());
        end
        n_tests++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL delay_stable: %0d unstable cycles, required 0", stab_err);
        end
    endtask

    task automatic test_abort();
        int n, lat;
        issue_cmd(2'd0, 32'h0000_0300, 1'b0);
        n = 0;
        while (!(bus.state_dbg === 4'd5 && got_q.size() >= 10) && n < 500) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (bus.state_dbg !== 4'd5 || bus.req_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach_pdata: state=%0d req_tx=%b, required 5/1", bus.state_dbg, bus.req_tx);
        end
        #2 rstn = 1'b0;
        #1;
        n_tests++;
        if ({bus.req_tx, bus.type_tx, bus.req_rx, bus.finish} !== 4'b0 ||
            bus.dout_tx !== 32'h0 || bus.addr !== '0 || bus.state_dbg !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: req_tx=%b type_tx=%b dout_tx=%h addr=%h state=%0d, required all 0",
                     bus.req_tx, bus.type_tx, bus.dout_tx, bus.addr, bus.state_dbg);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (bus.state_dbg !== 4'd0 || bus.req_rx !== 1'b0 || bus.req_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: state=%0d req_rx=%b req_tx=%b, required 0/0/0",
                     bus.state_dbg, bus.req_rx, bus.req_tx);
        end
        run_cmd(2'd0, 32'h5555_5550, 1'b1, lat);
        n_tests++;
        if (got_q[0] !== {1'b1, 32'h0} || got_q[2] !== {1'b1, 32'hA5A5_0000}) begin
            n_fail++;
            $display("FAIL abort_continue_zero: got %h %h, required 100000000 1a5a50000", got_q[0], got_q[2]);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.start   = 1'b0;
        bus.ch      = '0;
        bus.ack_rx  = 1'b0;
        bus.flag_rx = 1'b0;
        bus.din_rx  = 32'h0;
        test_reset();
        test_basic();
        test_continue();
        test_channels();
        test_wrap();
        test_delays();
        test_abort();
        n_tests++;
        if (order_err !== 0) begin
            n_fail++;
            $display("FAIL output_order: %0d overlapping req/finish cycles, required 0", order_err);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
